// File: rtl/riscv_pkg.sv
// Shared core definitions: reset constants, instruction field
// positions, opcode map and the IF/ID bundle.
package riscv_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 6;
   localparam int RD_LSB  = 7;
   localparam int RD_MSB  = 11;
   localparam int F3_LSB  = 12;
   localparam int F3_MSB  = 14;
   localparam int RS1_LSB = 15;
   localparam int RS1_MSB = 19;
   localparam int RS2_LSB = 20;
   localparam int RS2_MSB = 24;
   localparam int F7_LSB  = 25;
   localparam int F7_MSB  = 31;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'h03,
      OP_IMM    = 7'h13,
      OP_AUIPC  = 7'h17,
      OP_STORE  = 7'h23,
      OP_REG    = 7'h33,
      OP_LUI    = 7'h37,
      OP_BRANCH = 7'h63,
      OP_JALR   = 7'h67,
      OP_JAL    = 7'h6F,
      OP_SYSTEM = 7'h73
   } opcode_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/pc_register.sv
// Fetch PC flop with next-PC selection and a registered
// misaligned-redirect pulse.
module pc_register
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall_f,
   input  logic        redirect_e,
   input  logic [31:0] redirect_pc_e,
   output logic [31:0] pc_f,
   output logic        misalign_e
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_f       <= RESET_PC;
         misalign_e <= 1'b0;
      end else begin
         misalign_e <= redirect_e && (redirect_pc_e[1:0] != 2'b00);
         // a resolved branch must never be blocked by a stall
         priority case (1'b1)
            redirect_e: pc_f <= {redirect_pc_e[31:2], 2'b00};
            stall_f:    pc_f <= pc_f;
            default:    pc_f <= pc_f + 32'd4;
         endcase
      end
   end

endmodule

// File: rtl/fetch_decode_stage.sv
// IF stage and IF/ID pipeline register: fetch, capture, field
// slicing and a saturating bubble counter.
module fetch_decode_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall_f,
   input  logic             stall_d,
   input  logic             flush_d,
   input  logic             redirect_e,
   input  logic [31:0]      redirect_pc_e,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      pc_f,
   output logic [31:0]      instr_d,
   output logic [31:0]      pc_d,
   output logic [31:0]      pc_plus4_d,
   output logic             valid_d,
   output logic [6:0]       opcode_d,
   output logic [2:0]       funct3_d,
   output logic [6:0]       funct7_d,
   output logic [4:0]       rd_d,
   output logic [4:0]       rs1_d,
   output logic [4:0]       rs2_d,
   output logic             misalign_e,
   output logic [CNT_W-1:0] bubble_cnt
);

   if_id_t if_id;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall_f       (stall_f),
      .redirect_e    (redirect_e),
      .redirect_pc_e (redirect_pc_e),
      .pc_f          (pc_f),
      .misalign_e    (misalign_e)
   );

   assign imem_addr = pc_f;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         if_id.instr    <= NOP_INSTR;
         if_id.pc       <= 32'd0;
         if_id.pc_plus4 <= 32'd4;
         if_id.valid    <= 1'b0;
      end else begin
         // flush keeps pc_d so the squashed slot still has a PC
         priority case (1'b1)
            flush_d: begin
               if_id.instr <= NOP_INSTR;
               if_id.valid <= 1'b0;
            end
            stall_d: if_id <= if_id;
            default: begin
               if_id.instr    <= imem_rdata;
               if_id.pc       <= pc_f;
               if_id.pc_plus4 <= pc_f + 32'd4;
               if_id.valid    <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bubble_cnt <= '0;
      end else if (!if_id.valid && (bubble_cnt != '1)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

   assign instr_d    = if_id.instr;
   assign pc_d       = if_id.pc;
   assign pc_plus4_d = if_id.pc_plus4;
   assign valid_d    = if_id.valid;

   assign opcode_d = if_id.instr[OPC_MSB:OPC_LSB];
   assign rd_d     = if_id.instr[RD_MSB:RD_LSB];
   assign funct3_d = if_id.instr[F3_MSB:F3_LSB];
   assign rs1_d    = if_id.instr[RS1_MSB:RS1_LSB];
   assign rs2_d    = if_id.instr[RS2_MSB:RS2_LSB];
   assign funct7_d = if_id.instr[F7_MSB:F7_LSB];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed table, reset/saturation
// sequence and randomized run against a spec-level model.
module tb_fetch_decode_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall_f, stall_d, flush_d, redirect_e;
   logic [31:0] redirect_pc_e;
   logic [31:0] imem_addr, imem_rdata, pc_f;
   logic [31:0] instr_d, pc_d, pc_plus4_d;
   logic        valid_d, misalign_e;
   logic [6:0]  opcode_d, funct7_d;
   logic [2:0]  funct3_d;
   logic [4:0]  rd_d, rs1_d, rs2_d;
   logic [15:0] bubble_cnt;

   logic [31:0] imem_addr2, pc_f2, instr_d2, pc_d2, pc_plus4_d2;
   logic        valid_d2, misalign_e2;
   logic [6:0]  opcode_d2, funct7_d2;
   logic [2:0]  funct3_d2;
   logic [4:0]  rd_d2, rs1_d2, rs2_d2;
   logic [1:0]  bubble_cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   assign imem_rdata = word(imem_addr);

   fetch_decode_stage dut (
      .clk(clk), .reset_n(reset_n), .stall_f(stall_f),
      .stall_d(stall_d), .flush_d(flush_d),
      .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
      .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
      .opcode_d(opcode_d), .funct3_d(funct3_d),
      .funct7_d(funct7_d), .rd_d(rd_d), .rs1_d(rs1_d),
      .rs2_d(rs2_d), .misalign_e(misalign_e),
      .bubble_cnt(bubble_cnt)
   );

   fetch_decode_stage #(.CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .stall_f(stall_f),
      .stall_d(stall_d), .flush_d(flush_d),
      .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e),
      .imem_addr(imem_addr2), .imem_rdata(imem_rdata),
      .pc_f(pc_f2), .instr_d(instr_d2), .pc_d(pc_d2),
      .pc_plus4_d(pc_plus4_d2), .valid_d(valid_d2),
      .opcode_d(opcode_d2), .funct3_d(funct3_d2),
      .funct7_d(funct7_d2), .rd_d(rd_d2), .rs1_d(rs1_d2),
      .rs2_d(rs2_d2), .misalign_e(misalign_e2),
      .bubble_cnt(bubble_cnt2)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag,
                            input logic [31:0] e_pcf,
                            input logic [31:0] e_pcd,
                            input logic e_v, input logic e_mis,
                            input int e_cnt);
      logic [31:0] ei;
      ei = e_v ? word(e_pcd) : NOP;
      chk({tag, " pc_f"}, pc_f, e_pcf);
      chk({tag, " imem_addr"}, imem_addr, e_pcf);
      chk({tag, " instr_d"}, instr_d, ei);
      chk({tag, " fields"}, {funct7_d, rs2_d, rs1_d, funct3_d,
                             rd_d, opcode_d}, ei);
      chk({tag, " pc_d"}, pc_d, e_pcd);
      chk({tag, " pc_plus4_d"}, pc_plus4_d, e_pcd + 32'd4);
      chk({tag, " valid_d"}, 32'(valid_d), 32'(e_v));
      chk({tag, " misalign_e"}, 32'(misalign_e), 32'(e_mis));
      chk({tag, " bubble_cnt"}, 32'(bubble_cnt),
          (e_cnt > 65535) ? 32'd65535 : 32'(e_cnt));
      chk({tag, " bubble_cnt2"}, 32'(bubble_cnt2),
          (e_cnt > 3) ? 32'd3 : 32'(e_cnt));
      chk({tag, " dut2 pc_f"}, pc_f2, e_pcf);
   endtask

   typedef struct {
      logic        sf, sd, fl, rd;
      logic [31:0] rpc, pcf, pcd;
      logic        v, mis;
      int          cnt;
   } vec_t;

   vec_t tbl[20];

   // spec-level reference state
   logic [31:0] m_pc, m_pcd;
   logic        m_v, m_mis;
   int          m_cnt;

   task automatic idle_inputs();
      stall_f = 0; stall_d = 0; flush_d = 0;
      redirect_e = 0; redirect_pc_e = 32'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      m_pc = 32'd0; m_pcd = 32'd0; m_v = 0; m_mis = 0; m_cnt = 0;
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      check_all("rst", 32'h0, 32'h0, 1'b0, 1'b0, 0);
      reset_n = 1'b1;

      tbl[0]  = '{0,0,0,0,32'h0,32'h4,32'h0,1,0,1};
      tbl[1]  = '{0,0,0,0,32'h0,32'h8,32'h4,1,0,1};
      tbl[2]  = '{0,0,0,0,32'h0,32'hC,32'h8,1,0,1};
      tbl[3]  = '{0,0,0,0,32'h0,32'h10,32'hC,1,0,1};
      tbl[4]  = '{1,1,0,0,32'h0,32'h10,32'hC,1,0,1};
      tbl[5]  = '{1,1,0,0,32'h0,32'h10,32'hC,1,0,1};
      tbl[6]  = '{1,1,0,0,32'h0,32'h10,32'hC,1,0,1};
      tbl[7]  = '{0,0,0,0,32'h0,32'h14,32'h10,1,0,1};
      tbl[8]  = '{1,0,1,1,32'h200,32'h200,32'h10,0,0,1};
      tbl[9]  = '{0,0,0,0,32'h0,32'h204,32'h200,1,0,2};
      tbl[10] = '{0,0,0,1,32'h103,32'h100,32'h204,1,1,2};
      tbl[11] = '{0,0,0,0,32'h0,32'h104,32'h100,1,0,2};
      tbl[12] = '{1,0,0,0,32'h0,32'h104,32'h104,1,0,2};
      tbl[13] = '{0,0,0,0,32'h0,32'h108,32'h104,1,0,2};
      tbl[14] = '{0,1,1,0,32'h0,32'h10C,32'h104,0,0,2};
      tbl[15] = '{0,1,0,0,32'h0,32'h110,32'h104,0,0,3};
      tbl[16] = '{0,0,0,0,32'h0,32'h114,32'h110,1,0,4};
      tbl[17] = '{0,0,0,1,32'hFFFF_FFFC,32'hFFFF_FFFC,32'h114,1,0,4};
      tbl[18] = '{0,0,0,0,32'h0,32'h0,32'hFFFF_FFFC,1,0,4};
      tbl[19] = '{0,0,0,0,32'h0,32'h4,32'h0,1,0,4};

      for (int i = 0; i < 20; i++) begin
         stall_f = tbl[i].sf; stall_d = tbl[i].sd;
         flush_d = tbl[i].fl; redirect_e = tbl[i].rd;
         redirect_pc_e = tbl[i].rpc;
         @(posedge clk); #1;
         check_all($sformatf("vec%0d", i), tbl[i].pcf, tbl[i].pcd,
                   tbl[i].v, tbl[i].mis, tbl[i].cnt);
         @(negedge clk);
      end

      // async reset landing mid-cycle while a flush/redirect is pending
      flush_d = 1; redirect_e = 1; redirect_pc_e = 32'h300;
      #2 reset_n = 1'b0;
      #1 check_all("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 0);
      @(negedge clk);
      check_all("rst_hold", 32'h0, 32'h0, 1'b0, 1'b0, 0);
      reset_n = 1'b1;
      redirect_e = 0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         check_all($sformatf("sat%0d", k), 32'(4 * k), 32'h0,
                   1'b0, 1'b0, k);
         @(negedge clk);
      end

      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic [31:0] nx_pc;
         stall_f = ($urandom_range(0, 3) == 0);
         stall_d = ($urandom_range(0, 3) == 0);
         flush_d = ($urandom_range(0, 7) == 0);
         redirect_e = ($urandom_range(0, 9) == 0);
         redirect_pc_e = $urandom;
         if (redirect_e) nx_pc = redirect_pc_e & ~32'd3;
         else if (stall_f) nx_pc = m_pc;
         else nx_pc = m_pc + 32'd4;
         m_mis = redirect_e && (redirect_pc_e % 4 != 0);
         if (!m_v) m_cnt = m_cnt + 1;
         if (flush_d) m_v = 0;
         else if (!stall_d) begin
            m_v = 1; m_pcd = m_pc;
         end
         m_pc = nx_pc;
         @(posedge clk); #1;
         check_all($sformatf("rnd%0d", n), m_pc, m_pcd, m_v, m_mis,
                   m_cnt);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
